xor3_response_checker: RTL and testbench
========================================

// Module: xor3_response_checker
// PURPOSE
//  Checking end of the 3-input XOR truth-table flow: accepts each applied input vector plus the gate's observed output,
//  compares the output against the expected parity after a fixed settle delay, and tallies errors.
//  Sits beside the gate under test opposite the vector source; gives a synthesizable on-chip pass/fail verdict.
// PARAMETERS
//  N_IN        3   width of applied input vector
//  N_VEC       8   vectors per run (normally 2**N_IN)
//  CNT_W       4   width of vec_count/err_count; must hold N_VEC
//  SAMPLE_DLY  1   clk cycles from vector acceptance to sampling dut_out (>=1)
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      synchronous, active-high reset
//  start            in   1      one-cycle pulse: begin a run (honoured only in IDLE or DONE)
//  vec_valid        in   1      vec_in holds a vector just applied to the gate
//  vec_in           in   N_IN   applied vector, {i1,i2,i3} order, MSB = i1
//  dut_out          in   1      observed gate output
//  vec_ready        out  1      checker can accept a vector this cycle
//  busy             out  1      run in progress (WAIT_VEC or SAMPLE)
//  done             out  1      run complete; held until start or reset
//  pass             out  1      valid when done: 1 = no errors (and coverage met if enabled)
//  vec_count        out  CNT_W  vectors checked this run
//  err_count        out  CNT_W  mismatches this run, saturating at 2**CNT_W-1
//  first_fail_vec   out  N_IN   vector of first mismatch
//  first_fail_seen  out  1      first_fail_vec holds a real value
//  cov_full         out  1      every vector 0..2**N_IN-1 checked at least once
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; internal latch, delay counter and coverage bitmap cleared. Reset mid-run aborts.
//  - FSM IDLE -> WAIT_VEC on start; counters, first_fail_* and bitmap cleared the same edge.
//  - WAIT_VEC: vec_ready=1. On vec_valid&vec_ready: latch vec_in, load dly=SAMPLE_DLY-1, -> SAMPLE.
//  - SAMPLE: vec_ready=0; vec_valid ignored. dly counts down; in the cycle dly==0 compare dut_out with ^latched_vec.
//    Mismatch: err_count+1 (saturating); if !first_fail_seen capture latched vec, set first_fail_seen.
//    vec_count+1; if new vec_count==N_VEC -> DONE, else -> WAIT_VEC (next vector accepted earliest one cycle later).
//  - Per-vector throughput: SAMPLE_DLY+1 cycles; with SAMPLE_DLY=1 a run of 8 takes 16 cycles min after start.
//  - DONE: done=1, busy=0, pass=(err_count==0)[&cov_full if enabled]; counts frozen. start -> WAIT_VEC, clears as above.
//  - start while busy ignored. start and reset together: reset wins.
//  - pass reads 0 outside DONE. err_count saturation does not change pass (still 0).
//  - Registered outputs only; all update on the clk edge following the causing condition.
// CONFIGURATION
//  CHK_COVERAGE_EN defined: 2**N_IN-bit bitmap; bit[latched_vec] set at each compare; cov_full=&bitmap;
//    pass additionally requires cov_full. Duplicate vectors count toward vec_count but not coverage.
//  CHK_COVERAGE_EN undefined: no bitmap logic; cov_full tied 1; pass depends on err_count only.
// TESTING
//  1 start, apply vectors 0..7 with true XOR model, SAMPLE_DLY=1 -> done=1, pass=1, err_count=0, vec_count=8, cov_full=1.
//  2 dut_out stuck 0, vectors 0..7 -> err_count=4, first_fail_vec=3'b001, first_fail_seen=1, pass=0.
//  3 vec_valid held high continuously -> vec_ready toggles 1/0, exactly 8 vectors taken, done 16 cycles after start.
//  4 reset asserted after 3rd vector -> next cycle all outputs 0, vec_ready=0; new start runs cleanly to pass=1.
//  5 vector 3'b000 applied 8 times, correct dut_out -> with CHK_COVERAGE_EN: cov_full=0, pass=0; without: pass=1.
//  6 start pulsed during SAMPLE mid-run -> ignored: vec_count continues, no clear; start in DONE restarts with counts 0.

Source files
------------

// File: rtl/xor3_response_checker.sv
// -----------------------------------------------------------------------------
// xor3_response_checker
//
// Checking end of a 3-input XOR truth-table run. Each vector applied to the
// gate under test is handed to this block together with the gate's observed
// output. After a fixed settle delay the output is compared with the parity
// of the vector. Mismatches are counted and the first failing vector is kept,
// which gives an on-chip pass/fail verdict.
//
// Optional feature macro: CHK_COVERAGE_EN
//   defined   : keeps a 2**N_IN-bit bitmap of the vectors checked. cov_full_o is
//               the AND of the bitmap, and pass_o also requires full coverage.
//   undefined : no bitmap. cov_full_o is tied to 1, and pass_o depends on the
//               error count only.
//
// Ports
//   clk_i              rising-edge clock
//   reset_i            synchronous, active-high reset (aborts a run)
//   start_i            one-cycle pulse that begins a run (honoured in IDLE/DONE)
//   vec_valid_i        vec_in_i holds a vector just applied to the gate
//   vec_in_i           applied vector {i1,i2,i3}, MSB = i1
//   dut_out_i          observed gate output
//   vec_ready_o        checker accepts a vector this cycle
//   busy_o             run in progress (WAIT_VEC or SAMPLE)
//   done_o             run complete; held until start or reset
//   pass_o             meaningful in DONE: 1 = no errors (and coverage met)
//   vec_count_o        vectors checked this run
//   err_count_o        mismatches this run, saturating
//   first_fail_vec_o   vector of the first mismatch
//   first_fail_seen_o  first_fail_vec_o holds a real value
//   cov_full_o         every code 0..2**N_IN-1 checked at least once
//   state_o            current FSM state (debug visibility)
//
// Handshake: a vector transfers on a rising edge where vec_valid_i and
// vec_ready_o are both 1. vec_ready_o never depends combinationally on
// vec_valid_i, and vec_valid_i is ignored while vec_ready_o is 0.
// -----------------------------------------------------------------------------
module xor3_response_checker #(
    parameter int N_IN       = 3,
    parameter int N_VEC      = 8,
    parameter int CNT_W      = 4,
    parameter int SAMPLE_DLY = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             vec_valid_i,
    input  logic [N_IN-1:0]  vec_in_i,
    input  logic             dut_out_i,
    output logic             vec_ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] vec_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [N_IN-1:0]  first_fail_vec_o,
    output logic             first_fail_seen_o,
    output logic             cov_full_o,
    output logic [1:0]       state_o
);

    localparam int DLY_W = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VEC = 2'd1,
        SAMPLE   = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [N_IN-1:0]  vec_lat_q, vec_lat_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]  ff_vec_q, ff_vec_d;
    logic             ff_seen_q, ff_seen_d;
    logic             vec_ready_q, vec_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             cov_ok_d;

    logic             clear_run;
    logic             accept;
    logic             compare_now;
    logic             mismatch;
    logic [CNT_W-1:0] vec_cnt_inc;

    // The start pulse only clears and launches a run from IDLE or DONE.
    // A pulse while busy is dropped.
    assign clear_run   = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign accept      = (state_q == WAIT_VEC) && vec_valid_i;
    assign compare_now = (state_q == SAMPLE) && (dly_q == '0);
    assign mismatch    = dut_out_i != (^vec_lat_q);
    assign vec_cnt_inc = vec_cnt_q + 1'b1;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_i) state_d = WAIT_VEC;
            WAIT_VEC: if (vec_valid_i) state_d = SAMPLE;
            SAMPLE: begin
                if (compare_now) begin
                    state_d = (vec_cnt_inc == CNT_W'(N_VEC)) ? DONE : WAIT_VEC;
                end
            end
            DONE:     if (start_i) state_d = WAIT_VEC;
            default:  state_d = IDLE;
        endcase
    end

    // --------------------------------------------------------- datapath next
    always_comb begin
        vec_lat_d = vec_lat_q;
        dly_d     = dly_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        ff_vec_d  = ff_vec_q;
        ff_seen_d = ff_seen_q;

        if (clear_run) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
            ff_vec_d  = '0;
            ff_seen_d = 1'b0;
        end

        if (accept) begin
            vec_lat_d = vec_in_i;
            dly_d     = DLY_W'(SAMPLE_DLY - 1);
        end

        if (state_q == SAMPLE) begin
            if (dly_q != '0) begin
                dly_d = dly_q - 1'b1;
            end else begin
                vec_cnt_d = vec_cnt_inc;
                if (mismatch) begin
                    // Saturate so a long run cannot wrap back to zero errors.
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    if (!ff_seen_q) begin
                        ff_vec_d  = vec_lat_q;
                        ff_seen_d = 1'b1;
                    end
                end
            end
        end
    end

`ifdef CHK_COVERAGE_EN
    logic [(1<<N_IN)-1:0] bitmap_q, bitmap_d;
    logic                 cov_full_q;

    always_comb begin
        bitmap_d = bitmap_q;
        if (clear_run) bitmap_d = '0;
        if (compare_now) bitmap_d[vec_lat_q] = 1'b1;
    end

    assign cov_ok_d = &bitmap_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bitmap_q   <= '0;
            cov_full_q <= 1'b0;
        end else begin
            bitmap_q   <= bitmap_d;
            cov_full_q <= cov_ok_d;
        end
    end

    assign cov_full_o = cov_full_q;
`else
    assign cov_ok_d   = 1'b1;
    assign cov_full_o = 1'b1;
`endif

    // ------------------------------------------------------------ output comb
    // The flags are computed from the next state, so each registered output
    // changes on the same edge as the state it reflects.
    always_comb begin
        vec_ready_d = (state_d == WAIT_VEC);
        busy_d      = (state_d == WAIT_VEC) || (state_d == SAMPLE);
        done_d      = (state_d == DONE);
        pass_d      = done_d && (err_cnt_d == '0) && cov_ok_d;
    end

    // -------------------------------------------------------- datapath/outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vec_lat_q   <= '0;
            dly_q       <= '0;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ff_vec_q    <= '0;
            ff_seen_q   <= 1'b0;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            vec_lat_q   <= vec_lat_d;
            dly_q       <= dly_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ff_vec_q    <= ff_vec_d;
            ff_seen_q   <= ff_seen_d;
            vec_ready_q <= vec_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign vec_ready_o       = vec_ready_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign vec_count_o       = vec_cnt_q;
    assign err_count_o       = err_cnt_q;
    assign first_fail_vec_o  = ff_vec_q;
    assign first_fail_seen_o = ff_seen_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_xor3_response_checker.sv
// -----------------------------------------------------------------------------
// Bench for xor3_response_checker. A gate model drives dut_out from vec_in,
// either as a true 3-input XOR or stuck at 0. Each scenario task drives its own
// stimulus and compares the outputs inline, on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xor3_response_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic       vec_valid;
    logic [2:0] vec_in;
    logic       dut_out;
    logic       vec_ready;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] vec_count;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       first_fail_seen;
    logic       cov_full;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int gate_mode = 0;        // 0: true XOR, 1: stuck at 0
    logic [2:0] vecs [8];

`ifdef CHK_COVERAGE_EN
    localparam logic COV_AFTER_RESET = 1'b0;
    localparam logic PASS_DUP        = 1'b0;
    localparam logic COV_DUP         = 1'b0;
`else
    localparam logic COV_AFTER_RESET = 1'b1;
    localparam logic PASS_DUP        = 1'b1;
    localparam logic COV_DUP         = 1'b1;
`endif

    assign dut_out = (gate_mode == 0) ? ^vec_in : 1'b0;

    xor3_response_checker #(
        .N_IN(3), .N_VEC(8), .CNT_W(4), .SAMPLE_DLY(1)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_i          (start),
        .vec_valid_i      (vec_valid),
        .vec_in_i         (vec_in),
        .dut_out_i        (dut_out),
        .vec_ready_o      (vec_ready),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .vec_count_o      (vec_count),
        .err_count_o      (err_count),
        .first_fail_vec_o (first_fail_vec),
        .first_fail_seen_o(first_fail_seen),
        .cov_full_o       (cov_full),
        .state_o          (state)
    );

    // ------------------------------------------------------ clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_in = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (vec_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_ready: vec_ready stayed 0 for 20 cycles, required 1");
        end
    endtask

    // Applies vecs[first .. first+n-1]; returns on the negedge after the last accept.
    task automatic run_vectors(input int first, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_ready(ok);
            if (!ok) return;
            vec_in    = vecs[first + i];
            vec_valid = 1'b1;
            @(negedge clk);
            vec_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_done: done stayed 0 for 20 cycles, required 1");
        end
    endtask

    task automatic load_counting();
        for (int i = 0; i < 8; i++) vecs[i] = 3'(i);
    endtask

    // ------------------------------------------------------------ scenarios
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({vec_ready, busy, done, pass, first_fail_seen} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {vec_ready, busy, done, pass, first_fail_seen});
        end
        n_checks++;
        if ({vec_count, err_count, first_fail_vec} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got vec=%0d err=%0d ffv=%0d required 0 0 0",
                     vec_count, err_count, first_fail_vec);
        end
        n_checks++;
        if (cov_full !== COV_AFTER_RESET) begin
            n_fail++;
            $display("FAIL reset_cov: got %b required %b", cov_full, COV_AFTER_RESET);
        end
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required 0", state);
        end
    endtask

    task automatic test_true_xor();
        apply_reset();
        gate_mode = 0;
        load_counting();
        pulse_start();
        n_checks++;
        if ({vec_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL xor_after_start: ready/busy got %b required 11", {vec_ready, busy});
        end
        run_vectors(0, 8);
        wait_done();
        n_checks++;
        if ({done, pass, busy, vec_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL xor_done_flags: got %b required 1100", {done, pass, busy, vec_ready});
        end
        n_checks++;
        if (vec_count !== 4'd8 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL xor_counts: got vec=%0d err=%0d required 8 0", vec_count, err_count);
        end
        n_checks++;
        if (cov_full !== 1'b1 || first_fail_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL xor_cov_ff: got cov=%b seen=%b required 1 0", cov_full, first_fail_seen);
        end
        // Done and the frozen counts hold while idle in DONE.
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || vec_count !== 4'd8) begin
            n_fail++;
            $display("FAIL xor_done_hold: got done=%b vec=%0d required 1 8", done, vec_count);
        end
    endtask

    task automatic test_stuck_zero();
        apply_reset();
        gate_mode = 1;
        load_counting();
        pulse_start();
        run_vectors(0, 8);
        wait_done();
        n_checks++;
        if (err_count !== 4'd4) begin
            n_fail++;
            $display("FAIL stuck_err_count: got %0d required 4", err_count);
        end
        n_checks++;
        if (first_fail_vec !== 3'b001 || first_fail_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_first_fail: got vec=%b seen=%b required 001 1",
                     first_fail_vec, first_fail_seen);
        end
        n_checks++;
        if (pass !== 1'b0 || done !== 1'b1 || vec_count !== 4'd8 || cov_full !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_verdict: got pass=%b done=%b vec=%0d cov=%b required 0 1 8 1",
                     pass, done, vec_count, cov_full);
        end
        gate_mode = 0;
    endtask

    task automatic test_back_to_back();
        int idx;
        int bad_ready;
        int bad_done;
        apply_reset();
        gate_mode = 0;
        idx = 0;
        bad_ready = 0;
        bad_done = 0;
        start = 1'b1;
        vec_valid = 1'b1;
        vec_in = 3'd0;
        // Edge k = 0 is the start edge; the loop observes after each edge k.
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k < 16 && vec_ready !== ((k % 2) == 0)) bad_ready++;
            if (done !== (k == 16)) bad_done++;
            if (vec_ready) begin
                vec_in = 3'(idx);
                idx++;
            end
        end
        n_checks++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL b2b_ready_toggle: got %0d wrong cycles required 0", bad_ready);
        end
        n_checks++;
        if (bad_done != 0) begin
            n_fail++;
            $display("FAIL b2b_done_time: got %0d wrong cycles required 0 (done at cycle 16)", bad_done);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (vec_count !== 4'd8 || vec_ready !== 1'b0 || pass !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_taken: got vec=%0d ready=%b pass=%b required 8 0 1",
                     vec_count, vec_ready, pass);
        end
        vec_valid = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        gate_mode = 0;
        load_counting();
        pulse_start();
        run_vectors(0, 3);
        @(negedge clk);
        n_checks++;
        if (vec_count !== 4'd3) begin
            n_fail++;
            $display("FAIL midrst_before: vec_count got %0d required 3", vec_count);
        end
        reset = 1'b1;
        start = 1'b1;   // reset wins over a simultaneous start
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({vec_ready, busy, done, pass, first_fail_seen} !== 5'b0 ||
            vec_count !== 4'd0 || err_count !== 4'd0 || first_fail_vec !== 3'd0 ||
            cov_full !== COV_AFTER_RESET) begin
            n_fail++;
            $display("FAIL midrst_cleared: got rdy=%b busy=%b done=%b pass=%b vec=%0d err=%0d cov=%b required all 0 (cov %b)",
                     vec_ready, busy, done, pass, vec_count, err_count, cov_full, COV_AFTER_RESET);
        end
        @(negedge clk);
        pulse_start();
        run_vectors(0, 8);
        wait_done();
        n_checks++;
        if (pass !== 1'b1 || vec_count !== 4'd8 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL midrst_rerun: got pass=%b vec=%0d err=%0d required 1 8 0",
                     pass, vec_count, err_count);
        end
    endtask

    task automatic test_duplicates();
        apply_reset();
        gate_mode = 0;
        for (int i = 0; i < 8; i++) vecs[i] = 3'b000;
        pulse_start();
        run_vectors(0, 8);
        wait_done();
        n_checks++;
        if (vec_count !== 4'd8 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL dup_counts: got vec=%0d err=%0d required 8 0", vec_count, err_count);
        end
        n_checks++;
        if (pass !== PASS_DUP || cov_full !== COV_DUP) begin
            n_fail++;
            $display("FAIL dup_verdict: got pass=%b cov=%b required %b %b",
                     pass, cov_full, PASS_DUP, COV_DUP);
        end
    endtask

    task automatic test_start_ignored();
        apply_reset();
        gate_mode = 1;
        load_counting();
        pulse_start();
        run_vectors(0, 2);
        // Now in SAMPLE for vector 1 (a mismatch); this start must be dropped.
        pulse_start();
        n_checks++;
        if (vec_count !== 4'd2 || err_count !== 4'd1 || busy !== 1'b1 || first_fail_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_start_mid: got vec=%0d err=%0d busy=%b seen=%b required 2 1 1 1",
                     vec_count, err_count, busy, first_fail_seen);
        end
        run_vectors(2, 6);
        wait_done();
        n_checks++;
        if (vec_count !== 4'd8 || err_count !== 4'd4 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_start_end: got vec=%0d err=%0d pass=%b required 8 4 0",
                     vec_count, err_count, pass);
        end
        pulse_start();
        n_checks++;
        if (vec_count !== 4'd0 || err_count !== 4'd0 || first_fail_seen !== 1'b0 ||
            first_fail_vec !== 3'd0 || done !== 1'b0 || pass !== 1'b0 ||
            vec_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: got vec=%0d err=%0d seen=%b ffv=%b done=%b pass=%b rdy=%b busy=%b required 0 0 0 000 0 0 1 1",
                     vec_count, err_count, first_fail_seen, first_fail_vec, done, pass, vec_ready, busy);
        end
        gate_mode = 0;
    endtask

    // ----------------------------------------------------------------- main
    initial begin
        reset = 1'b1;
        start = 1'b0;
        vec_valid = 1'b0;
        vec_in = 3'b000;
        test_reset();
        test_true_xor();
        test_stuck_zero();
        test_back_to_back();
        test_reset_mid_run();
        test_duplicates();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
